// File: rtl/hdmi_tx_init_seq.sv
// hdmi_tx_init_seq: power-up sequencer for the SiI9022A HDMI transmitter.
// Owns an open-drain I2C master that writes a fixed six-entry register
// table (TPI mode, power, input/output format, TMDS enable), retrying each
// entry up to MAX_TRIES times on NACK.
// Optional build macro HDMI_INIT_ID_CHECK_EN: after entry 0, read register
// 0x1B and abort with err_code=2 unless it returns 0xB0. In that build the
// read transfer is reported as entry_idx 6.
module hdmi_tx_init_seq #(
    parameter int         CLK_FREQ_HZ = 100_000_000,
    parameter int         I2C_FREQ_HZ = 100_000,
    parameter logic [6:0] DEV_ADDR    = 7'h39,
    parameter int         MAX_TRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [2:0] entry_idx,
    output logic       scl_t,
    output logic       sda_t,
    input  logic       sda_i
);

    localparam int DIV = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(MAX_TRIES + 1);
`ifdef HDMI_INIT_ID_CHECK_EN
    localparam logic [2:0] RD_ENT = 3'd6;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_TXBIT, S_RXACK, S_RSTART,
        S_RXBIT, S_MACK, S_STOP, S_GAP, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [7:0]      tx_q, tx_d;
    logic [2:0]      entry_q, entry_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic            fail_q, fail_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            scl_q, scl_d;
    logic            sda_q, sda_d;
    logic            sda_s1_q, sda_s2_q;
`ifdef HDMI_INIT_ID_CHECK_EN
    logic [7:0]      rx_q, rx_d;
`endif

    logic tick;
    assign tick = (cnt_q == CW'(DIV - 1));

    // Byte idx of the transfer for table entry ent; entry 6 is the ID read
    // (addr+W, 0x1B, addr+R).
    function automatic logic [7:0] byte_val(input logic [2:0] ent, input logic [1:0] idx);
        logic [15:0] rd;
        logic [7:0]  b;
        case (ent)
            3'd0:    rd = 16'hC700;
            3'd1:    rd = 16'h1E00;
            3'd2:    rd = 16'h0870;
            3'd3:    rd = 16'h0902;
            3'd4:    rd = 16'h0A00;
            3'd5:    rd = 16'h1A01;
            default: rd = 16'h1B00;
        endcase
        case (idx)
            2'd0:    b = {DEV_ADDR, 1'b0};
            2'd1:    b = rd[15:8];
            2'd2:    b = (ent == 3'd6) ? {DEV_ADDR, 1'b1} : rd[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next entry in walk order; the ID read slots in after entry 0.
    function automatic logic [2:0] next_entry(input logic [2:0] ent);
`ifdef HDMI_INIT_ID_CHECK_EN
        if (ent == 3'd0)   return RD_ENT;
        if (ent == RD_ENT) return 3'd1;
`endif
        return ent + 3'd1;
    endfunction

    // Sequencer: every state is a whole number of 4-quarter units; decisions
    // are taken at the end of quarter 3, the bus is sampled at end of quarter 2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        entry_d = entry_q;
        tries_d = tries_q;
        fail_d  = fail_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
`ifdef HDMI_INIT_ID_CHECK_EN
        rx_d    = rx_q;
`endif
        if (state_q == S_IDLE || state_q == S_FIN) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            qtr_d   = 2'd0;
            if (start) begin
                state_d = S_START;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
                code_d  = 2'd0;
                entry_d = 3'd0;
                tries_d = '0;
                fail_d  = 1'b0;
                byte_d  = 2'd0;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) qtr_d = qtr_q + 2'd1;
            if (tick && qtr_q == 2'd2) begin
                if (state_q == S_RXACK) ack_d = ~sda_s2_q;
`ifdef HDMI_INIT_ID_CHECK_EN
                if (state_q == S_RXBIT) rx_d = {rx_q[6:0], sda_s2_q};
`endif
            end
            if (tick && qtr_q == 2'd3) begin
                case (state_q)
                    S_START: begin
                        state_d = S_TXBIT;
                        bit_d   = 3'd0;
                        tx_d    = byte_val(entry_q, byte_q);
                    end
                    S_TXBIT: begin
                        if (bit_q == 3'd7) state_d = S_RXACK;
                        else begin
                            bit_d = bit_q + 3'd1;
                            tx_d  = {tx_q[6:0], 1'b0};
                        end
                    end
                    S_RXACK: begin
                        if (!ack_q) begin
                            fail_d  = 1'b1;
                            state_d = S_STOP;
                        end
`ifdef HDMI_INIT_ID_CHECK_EN
                        else if (entry_q == RD_ENT && byte_q == 2'd1) begin
                            state_d = S_RSTART;
                            byte_d  = 2'd2;
                        end else if (entry_q == RD_ENT && byte_q == 2'd2) begin
                            state_d = S_RXBIT;
                            bit_d   = 3'd0;
                        end
`endif
                        else if (byte_q == 2'd2) state_d = S_STOP;
                        else begin
                            byte_d  = byte_q + 2'd1;
                            state_d = S_TXBIT;
                            bit_d   = 3'd0;
                            tx_d    = byte_val(entry_q, byte_q + 2'd1);
                        end
                    end
`ifdef HDMI_INIT_ID_CHECK_EN
                    S_RSTART: begin
                        state_d = S_TXBIT;
                        bit_d   = 3'd0;
                        tx_d    = byte_val(entry_q, 2'd2);
                    end
                    S_RXBIT: begin
                        if (bit_q == 3'd7) state_d = S_MACK;
                        else bit_d = bit_q + 3'd1;
                    end
                    S_MACK: state_d = S_STOP;
`endif
                    S_STOP: begin
                        if (fail_q && tries_q == TW'(MAX_TRIES - 1)) begin
                            state_d = S_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            code_d  = 2'd1;
                        end else state_d = S_GAP;
                    end
                    S_GAP: begin
                        byte_d = 2'd0;
                        if (fail_q) begin
                            tries_d = tries_q + 1'b1;
                            fail_d  = 1'b0;
                            state_d = S_START;
                        end
`ifdef HDMI_INIT_ID_CHECK_EN
                        else if (entry_q == RD_ENT && rx_q != 8'hB0) begin
                            state_d = S_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            code_d  = 2'd2;
                        end
`endif
                        else if (entry_q == 3'd5) begin
                            state_d = S_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            tries_d = '0;
                            entry_d = next_entry(entry_q);
                            state_d = S_START;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Line levels for the upcoming cycle, decoded from next state so SCL and
    // SDA are registered together.
    always_comb begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            S_START:                  sda_d = (qtr_d < 2'd2);
            S_TXBIT: begin
                scl_d = qtr_d[1];
                sda_d = tx_d[7];
            end
            S_RXACK, S_RXBIT, S_MACK: scl_d = qtr_d[1];
            S_RSTART: begin
                scl_d = (qtr_d != 2'd0);
                sda_d = (qtr_d < 2'd2);
            end
            S_STOP: begin
                scl_d = qtr_d[1];
                sda_d = (qtr_d == 2'd3);
            end
            default: ;
        endcase
    end

    // State registers; reset releases both lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            qtr_q    <= 2'd0;
            bit_q    <= 3'd0;
            byte_q   <= 2'd0;
            tx_q     <= 8'hFF;
            entry_q  <= 3'd0;
            tries_q  <= '0;
            fail_q   <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
`ifdef HDMI_INIT_ID_CHECK_EN
            rx_q     <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            entry_q  <= entry_d;
            tries_q  <= tries_d;
            fail_q   <= fail_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
`ifdef HDMI_INIT_ID_CHECK_EN
            rx_q     <= rx_d;
`endif
        end
    end

    // Two-flop synchroniser for the SDA pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
    assign entry_idx = entry_q;
    assign scl_t     = scl_q;
    assign sda_t     = sda_q;

endmodule

// File: tb/tb_hdmi_tx_init_seq.sv
// Bench for hdmi_tx_init_seq: I2C slave model on the bus, expected bytes
// queued when a sequence is launched and compared as the slave decodes them.
module tb_hdmi_tx_init_seq;

    localparam int DIV = 4;
    localparam int CLK_HZ = 1_600_000;
    localparam int I2C_HZ = 100_000;
`ifdef HDMI_INIT_ID_CHECK_EN
    localparam int ID_EN = 1;
`else
    localparam int ID_EN = 0;
`endif
    localparam int SEQ_CLK = (720 + ID_EN * 160) * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic [2:0] entry_idx;
    logic       scl_t, sda_t, sda_i;
    logic       slave_sda = 1'b1;

    assign sda_i = sda_t & slave_sda;

    always #5 clk = ~clk;

    hdmi_tx_init_seq #(
        .CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ), .DEV_ADDR(7'h39), .MAX_TRIES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .entry_idx(entry_idx),
        .scl_t(scl_t), .sda_t(sda_t), .sda_i(sda_i)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         n_start, n_stop;
    int         nack_mode = 0;     // 0 ack all, 1 nack address, 2 nack reg 0x09 once
    logic       nacked_once;
    logic [7:0] rd_data = 8'hB0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model / bus monitor
    logic       pscl, psda, ackph, rd_byte, rd_next, ack_now;
    int         bitn, bytei;
    logic [7:0] sh, e;
    initial begin
        pscl = 1; psda = 1; ackph = 0; rd_byte = 0; rd_next = 0; ack_now = 1;
        bitn = 0; bytei = 0; sh = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pscl = 1; psda = 1; ackph = 0; rd_byte = 0; rd_next = 0;
                bitn = 0; bytei = 0; slave_sda = 1;
            end else begin
                if (pscl && scl_t && psda && !sda_i) begin
                    n_start++; bitn = 0; ackph = 0; bytei = 0; rd_byte = 0;
                end else if (pscl && scl_t && !psda && sda_i) begin
                    n_stop++;
                end else if (!pscl && scl_t) begin
                    if (ackph) begin
                        if (rd_byte) chk("master_nack", sda_i, 1);
                    end else begin
                        sh = {sh[6:0], sda_i};
                        bitn++;
                        if (bitn == 8) begin
                            if (exp_q.size() == 0) chk("extra_byte", sh, 32'h100);
                            else begin
                                e = exp_q.pop_front();
                                chk("byte", sh, e);
                            end
                            ack_now = 1;
                            if (nack_mode == 1 && bytei == 0) ack_now = 0;
                            if (nack_mode == 2 && bytei == 1 && sh == 8'h09 && !nacked_once) begin
                                ack_now = 0;
                                nacked_once = 1;
                            end
                            if (!rd_byte && ack_now && sh == 8'h73) rd_next = 1;
                        end
                    end
                end else if (pscl && !scl_t) begin
                    if (bitn == 8 && !ackph) begin
                        ackph = 1;
                        slave_sda = (rd_byte || ack_now) ? rd_byte : 1'b1;
                        if (!rd_byte && ack_now) slave_sda = 0;
                    end else if (ackph) begin
                        ackph = 0; bitn = 0; bytei++; slave_sda = 1;
                        rd_byte = rd_next; rd_next = 0;
                        if (rd_byte) slave_sda = rd_data[7];
                    end else if (rd_byte && bitn < 8) begin
                        slave_sda = rd_data[7 - bitn];
                    end
                end
                pscl = scl_t;
                psda = sda_i;
            end
        end
    end

    task automatic push_wr(input logic [7:0] r, input logic [7:0] d);
        exp_q.push_back(8'h72); exp_q.push_back(r); exp_q.push_back(d);
    endtask

    task automatic push_read;
        exp_q.push_back(8'h72); exp_q.push_back(8'h1B);
        exp_q.push_back(8'h73); exp_q.push_back(rd_data);
    endtask

    task automatic push_rest(input int from);
        logic [7:0] regs [6];
        logic [7:0] dats [6];
        regs = '{8'hC7, 8'h1E, 8'h08, 8'h09, 8'h0A, 8'h1A};
        dats = '{8'h00, 8'h00, 8'h70, 8'h02, 8'h00, 8'h01};
        for (int i = from; i < 6; i++) begin
            push_wr(regs[i], dats[i]);
            if (i == 0 && ID_EN != 0) push_read();
        end
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3 * SEQ_CLK) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done", done, 1);
        chk("busy_low", busy, 0);
    endtask

    int cyc, rises;
    logic pd;
    initial begin
        n_start = 0; n_stop = 0; nacked_once = 0;
        #23;
        chk("rst_scl", scl_t, 1);
        chk("rst_sda", sda_t, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_idx", entry_idx, 0);
        rst_n = 1;

        // clean sequence with latency check
        push_rest(0);
        pulse_start();
        chk("busy_rise", busy, 1);
        wait_done(cyc);
        chk("clean_lat", (cyc >= SEQ_CLK - 2 && cyc <= SEQ_CLK + 2), 1);
        chk("clean_err", err, 0);
        chk("clean_code", err_code, 0);
        chk("clean_idx", entry_idx, 5);
        chk("clean_q", exp_q.size(), 0);

        // permanent address NACK
        nack_mode = 1; n_start = 0; n_stop = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h72);
        pulse_start();
        wait_done(cyc);
        chk("nack_starts", n_start, 3);
        chk("nack_stops", n_stop, 3);
        chk("nack_err", err, 1);
        chk("nack_code", err_code, 1);
        chk("nack_idx", entry_idx, 0);
        chk("nack_q", exp_q.size(), 0);

        // single NACK on entry 3 reg byte
        nack_mode = 2; nacked_once = 0; n_start = 0;
        push_rest(0);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h00);
        exp_q.delete();
        push_rest(0);
        begin
            logic [7:0] tmp[$];
            tmp = exp_q;
            exp_q.delete();
            for (int i = 0; i < tmp.size(); i++) begin
                if (i == 9 + 4 * ID_EN) begin
                    exp_q.push_back(8'h72); exp_q.push_back(8'h09);
                end
                exp_q.push_back(tmp[i]);
            end
        end
        pulse_start();
        wait_done(cyc);
        chk("retry_err", err, 0);
        chk("retry_starts", n_start, 7 + 2 * ID_EN);
        chk("retry_q", exp_q.size(), 0);

        // second start while busy is ignored
        nack_mode = 0;
        push_rest(0);
        repeat (10) @(posedge clk);
        pulse_start();
        repeat (990) @(posedge clk);
        pulse_start();
        rises = 0; pd = done;
        for (int i = 0; i < 2 * SEQ_CLK + 200; i++) begin
            @(posedge clk); #1;
            if (done && !pd) rises++;
            pd = done;
        end
        chk("done_once", rises, 1);
        chk("dbl_q", exp_q.size(), 0);

        // reset mid-byte of entry 2 (reg byte, bit 4)
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h00);
        exp_q.delete();
        push_wr(8'hC7, 8'h00);
        if (ID_EN != 0) push_read();
        push_wr(8'h1E, 8'h00);
        exp_q.push_back(8'h72);
        pulse_start();
        repeat (296 * DIV + ID_EN * 160 * DIV - 1) @(posedge clk);
        #1 chk("pre_rst_busy", busy, 1);
        #1 rst_n = 0;
        #1;
        chk("arst_scl", scl_t, 1);
        chk("arst_sda", sda_t, 1);
        chk("arst_busy", busy, 0);
        chk("arst_q", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk); rst_n = 1;
        push_rest(0);
        pulse_start();
        chk("restart_idx", entry_idx, 0);
        wait_done(cyc);
        chk("restart_err", err, 0);
        chk("restart_q", exp_q.size(), 0);

`ifdef HDMI_INIT_ID_CHECK_EN
        // wrong device ID: abort after the read
        rd_data = 8'hB4; n_start = 0;
        push_wr(8'hC7, 8'h00);
        push_read();
        pulse_start();
        wait_done(cyc);
        repeat (200 * DIV) @(posedge clk);
        chk("id_err", err, 1);
        chk("id_code", err_code, 2);
        chk("id_idx", entry_idx, 6);
        chk("id_starts", n_start, 3);
        chk("id_q", exp_q.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
